// File: rtl/intersection_scheduler_pkg.sv
// Shared types for the crossing scheduler.
// Light codes match the single-light FSM.
package traffic_pkg;

   localparam int CNT_W = 6;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      RED     = 2'd0,
      YELLOW1 = 2'd1,
      GREEN   = 2'd2,
      YELLOW2 = 2'd3
   } light_t;

   typedef enum logic [2:0] {
      ALLRED_A   = 3'd0,
      MAIN_PREP  = 3'd1,
      MAIN_GREEN = 3'd2,
      MAIN_YEL   = 3'd3,
      ALLRED_B   = 3'd4,
      SIDE_PREP  = 3'd5,
      SIDE_GREEN = 3'd6,
      SIDE_YEL   = 3'd7
   } state_t;

   function automatic logic is_main_phase(state_t s);
      return (s == MAIN_PREP) || (s == MAIN_GREEN)
          || (s == MAIN_YEL);
   endfunction

   function automatic logic light_jump(light_t a, light_t b);
      return (a == GREEN && b == RED)
          || (a == RED && b == GREEN);
   endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the scheduler and the
// crossing: tick, requests in, lamp drives out.
interface intersection_scheduler_if;
   import traffic_pkg::*;

   logic   tick;
   logic   btn_ped;
   logic   sensor_side;
   light_t main_light;
   light_t side_light;
   logic   walk;
   logic   req_pending;
   cnt_t   sec_left;

   modport master (
      input  tick, btn_ped, sensor_side,
      output main_light, side_light, walk,
      output req_pending, sec_left
   );

   modport slave (
      output tick, btn_ped, sensor_side,
      input  main_light, side_light, walk,
      input  req_pending, sec_left
   );

endinterface

// File: rtl/intersection_scheduler_sync_edge.sv
// Two-flop synchronizer for a raw async input.
// RISE=1 gives a one-clk rising-edge pulse.
module sync_edge #(
   parameter bit RISE = 1'b0
) (
   input  logic clk,
   input  logic res,
   input  logic din,
   output logic q
);

   logic s1, s2;

   // metastability filter
   always_ff @(posedge clk) begin
      if (!res) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   if (RISE) begin : g_rise
      logic s3;

      // previous synchronized value for edge detect
      always_ff @(posedge clk) begin
         if (!res) s3 <= 1'b0;
         else      s3 <= s2;
      end

      assign q = s2 & ~s3;
   end else begin : g_level
      assign q = s2;
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Main/side crossing sequencer with pedestrian
// and side-vehicle request arbitration.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int T_MAIN_MIN = 10,
   parameter int T_MAIN_MAX = 40,
   parameter int T_SIDE     = 21,
   parameter int T_YEL      = 3,
   parameter int T_ALLRED   = 2
) (
   input logic                       clk,
   input logic                       res,
   intersection_scheduler_if.master  bus
);

   localparam cnt_t D_MIN = cnt_t'(T_MAIN_MIN);
   localparam cnt_t D_MAX = cnt_t'(T_MAIN_MAX);
   localparam cnt_t D_SID = cnt_t'(T_SIDE);
   localparam cnt_t D_YEL = cnt_t'(T_YEL);
   localparam cnt_t D_ALR = cnt_t'(T_ALLRED);
   localparam cnt_t ONE   = cnt_t'(1);

   state_t state, state_nxt;
   cnt_t   cnt, cnt_nxt;
   cnt_t   dur;
   logic   ped_req, ped_nxt;
   logic   side_req, side_nxt;
   logic   walk_grant, grant_nxt;
   logic   ped_rise, side_lvl;
   logic   req_any, phase_end, to_side;

   sync_edge #(.RISE(1'b1)) u_ped (
      .clk (clk),
      .res (res),
      .din (bus.btn_ped),
      .q   (ped_rise)
   );

   sync_edge #(.RISE(1'b0)) u_side (
      .clk (clk),
      .res (res),
      .din (bus.sensor_side),
      .q   (side_lvl)
   );

   assign req_any = ped_req | side_req;

   // nominal length of the current phase
   always_comb begin
      dur = D_YEL;
      case (state)
         ALLRED_A,
         ALLRED_B:   dur = D_ALR;
         MAIN_GREEN: dur = D_MAX;
         SIDE_GREEN: dur = D_SID;
         default:    dur = D_YEL;
      endcase
   end

   // phase sequencing and request latching
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ped_nxt   = ped_req;
      side_nxt  = side_req;
      grant_nxt = walk_grant;
      phase_end = 1'b0;
      to_side   = 1'b0;

      if (state == MAIN_GREEN) begin
         phase_end = (cnt >= D_MIN - ONE && req_any)
                  || (cnt == D_MAX - ONE);
      end else begin
         phase_end = (cnt == dur - ONE);
      end

      if (bus.tick) begin
         if (phase_end) begin
            cnt_nxt = '0;
            case (state)
               ALLRED_A:   state_nxt = MAIN_PREP;
               MAIN_PREP:  state_nxt = MAIN_GREEN;
               MAIN_GREEN: state_nxt = MAIN_YEL;
               MAIN_YEL:   state_nxt = ALLRED_B;
               ALLRED_B:   state_nxt = SIDE_PREP;
               SIDE_PREP:  state_nxt = SIDE_GREEN;
               SIDE_GREEN: state_nxt = SIDE_YEL;
               SIDE_YEL:   state_nxt = ALLRED_A;
               default:    state_nxt = ALLRED_A;
            endcase
            to_side = (state == SIDE_PREP);
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end

      if (ped_rise && state != SIDE_GREEN)
         ped_nxt = 1'b1;
      if (side_lvl && is_main_phase(state))
         side_nxt = 1'b1;

      // entering side green serves both requests
      if (to_side) begin
         grant_nxt = ped_req;
         ped_nxt   = 1'b0;
         side_nxt  = 1'b0;
      end
   end

   // state, counter and request registers
   always_ff @(posedge clk) begin
      if (!res) begin
         state      <= ALLRED_A;
         cnt        <= '0;
         ped_req    <= 1'b0;
         side_req   <= 1'b0;
         walk_grant <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ped_req    <= ped_nxt;
         side_req   <= side_nxt;
         walk_grant <= grant_nxt;
      end
   end

   // lamp decode straight from the state register
   always_comb begin
      bus.main_light = RED;
      bus.side_light = RED;
      case (state)
         MAIN_PREP:  bus.main_light = YELLOW1;
         MAIN_GREEN: bus.main_light = GREEN;
         MAIN_YEL:   bus.main_light = YELLOW2;
         SIDE_PREP:  bus.side_light = YELLOW1;
         SIDE_GREEN: bus.side_light = GREEN;
         SIDE_YEL:   bus.side_light = YELLOW2;
         default: begin
            bus.main_light = RED;
            bus.side_light = RED;
         end
      endcase
   end

   assign bus.walk        = (state == SIDE_GREEN)
                          & walk_grant;
   assign bus.req_pending = req_any;
   assign bus.sec_left    = dur - cnt;

   a_excl: assert property (
      @(posedge clk)
      bus.main_light == RED || bus.side_light == RED
   );

   a_main_step: assert property (
      @(posedge clk) $past(res) |->
      !light_jump($past(bus.main_light), bus.main_light)
   );

   a_side_step: assert property (
      @(posedge clk) $past(res) |->
      !light_jump($past(bus.side_light), bus.side_light)
   );

   a_walk: assert property (
      @(posedge clk)
      !bus.walk || bus.side_light == GREEN
   );

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized scoreboard bench for the crossing
// scheduler against a table-driven phase model.
module tb_intersection_scheduler;

   localparam int T_MAIN_MIN = 10;
   localparam int T_MAIN_MAX = 40;
   localparam int T_SIDE     = 21;
   localparam int T_YEL      = 3;
   localparam int T_ALLRED   = 2;
   localparam int LIMIT      = 2000;

   // phase table in cyclic order:
   // ALLRED_A, MAIN_PREP, MAIN_GREEN, MAIN_YEL,
   // ALLRED_B, SIDE_PREP, SIDE_GREEN, SIDE_YEL
   localparam int PH_DUR[8] = '{T_ALLRED, T_YEL,
      T_MAIN_MAX, T_YEL, T_ALLRED, T_YEL, T_SIDE,
      T_YEL};
   localparam int MAIN_CODE[8] = '{0, 1, 2, 3,
      0, 0, 0, 0};
   localparam int SIDE_CODE[8] = '{0, 0, 0, 0,
      0, 1, 2, 3};

   typedef struct packed {
      logic [1:0] ml;
      logic [1:0] sl;
      logic       walk;
      logic       req;
      logic [5:0] sec;
   } exp_t;

   logic clk = 1'b0;
   logic res = 1'b0;

   intersection_scheduler_if bus();

   intersection_scheduler #(
      .T_MAIN_MIN (T_MAIN_MIN),
      .T_MAIN_MAX (T_MAIN_MAX),
      .T_SIDE     (T_SIDE),
      .T_YEL      (T_YEL),
      .T_ALLRED   (T_ALLRED)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   drv_done = 1'b0;

   int       m_ph, m_cnt;
   bit       m_ped, m_side, m_grant;
   bit [2:0] btn_seen;
   bit [1:0] sen_seen;

   // Reference: phase index into the table, tick
   // count in the phase, latched requests, and
   // the raw inputs as observed 1..3 clocks ago.
   function automatic void model_step(bit r, bit t,
                                      bit b, bit s);
      bit ped_edge, done, old_ped;
      if (!r) begin
         m_ph = 0; m_cnt = 0;
         m_ped = 0; m_side = 0; m_grant = 0;
         btn_seen = '0; sen_seen = '0;
         return;
      end
      ped_edge = btn_seen[1] && !btn_seen[2];
      old_ped  = m_ped;
      if (m_ph == 2)
         done = t && ((m_cnt >= T_MAIN_MIN - 1
                && (m_ped || m_side))
                || m_cnt == T_MAIN_MAX - 1);
      else
         done = t && m_cnt == PH_DUR[m_ph] - 1;
      if (ped_edge && m_ph != 6) m_ped = 1;
      if (sen_seen[1] && m_ph >= 1 && m_ph <= 3)
         m_side = 1;
      if (done && m_ph == 5) begin
         m_grant = old_ped;
         m_ped = 0;
         m_side = 0;
      end
      if (done) begin
         m_ph = (m_ph + 1) % 8;
         m_cnt = 0;
      end else if (t) begin
         m_cnt++;
      end
      btn_seen = {btn_seen[1:0], b};
      sen_seen = {sen_seen[0], s};
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.ml   = 2'(MAIN_CODE[m_ph]);
      e.sl   = 2'(SIDE_CODE[m_ph]);
      e.walk = (m_ph == 6) && m_grant;
      e.req  = m_ped || m_side;
      e.sec  = 6'(PH_DUR[m_ph] - m_cnt);
      return e;
   endfunction

   task automatic step(input bit r, input bit b,
                       input bit s);
      bit t;
      t = (cyc % 4 == 3);
      res = r;
      bus.tick = t;
      bus.btn_ped = b;
      bus.sensor_side = s;
      model_step(r, t, b, s);
      sb_q.push_back(model_out());
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int ph, input int cnt,
                         input bit b, input bit s,
                         input string tag);
      int g;
      g = 0;
      while (!(m_ph == ph && (cnt < 0 || m_cnt == cnt))
             && g < LIMIT) begin
         step(1'b1, b, s);
         g++;
      end
      if (g >= LIMIT) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout, got phase %0d cnt %0d, want phase %0d cnt %0d",
                  tag, m_ph, m_cnt, ph, cnt);
      end
   endtask

   // monitor: one expected sample per clock
   initial begin
      exp_t e, a;
      int   k;
      k = 0;
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() == 0) begin
            if (!drv_done) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: got no expectation, want one at sample %0d", k);
            end
         end else begin
            e = sb_q.pop_front();
            a.ml   = bus.main_light;
            a.sl   = bus.side_light;
            a.walk = bus.walk;
            a.req  = bus.req_pending;
            a.sec  = bus.sec_left;
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL sample%0d: got main=%0d side=%0d walk=%0b req=%0b sec=%0d, want main=%0d side=%0d walk=%0b req=%0b sec=%0d",
                        k, a.ml, a.sl, a.walk, a.req, a.sec,
                        e.ml, e.sl, e.walk, e.req, e.sec);
            end
            k++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no end of run, want summary");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      bit b, s;
      bus.tick = 1'b0;
      bus.btn_ped = 1'b0;
      bus.sensor_side = 1'b0;

      repeat (3) step(1'b0, 1'b0, 1'b0);

      // free run, one full cycle without requests
      repeat (330) step(1'b1, 1'b0, 1'b0);

      // pedestrian press early in main green
      run_to(2, 2, 1'b0, 1'b0, "t2_wait");
      repeat ($urandom_range(1, 6)) step(1'b1, 1'b1, 1'b0);
      run_to(7, -1, 1'b0, 1'b0, "t2_side");

      // side sensor held from main green cnt 25
      run_to(2, 25, 1'b0, 1'b0, "t3_wait");
      run_to(7, -1, 1'b0, 1'b1, "t3_side");
      run_to(0, -1, 1'b0, 1'b0, "t3_back");

      // press during side green is dropped
      run_to(6, 5, 1'b0, 1'b0, "t4_wait");
      repeat (3) step(1'b1, 1'b1, 1'b0);
      run_to(3, -1, 1'b0, 1'b0, "t4_main");

      // press landing on the side-green entry clk
      for (int pre = 0; pre < 2; pre++) begin
         if (pre == 1) begin
            run_to(2, 3, 1'b0, 1'b0, "t5_pre");
            repeat (3) step(1'b1, 1'b1, 1'b0);
         end
         run_to(5, 2, 1'b0, 1'b0, "t5_wait");
         while (cyc % 4 != 1) step(1'b1, 1'b0, 1'b0);
         repeat (5) step(1'b1, 1'b1, 1'b0);
         run_to(7, -1, 1'b0, 1'b0, "t5_side");
      end

      // reset mid side green on a tick clk
      run_to(6, 4, 1'b0, 1'b0, "t6_wait");
      while (cyc % 4 != 3) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b0, 1'b0);

      // random requests with rare resets
      b = 1'b0;
      s = 1'b0;
      repeat (2500) begin
         if ($urandom_range(0, 24) == 0) b = ~b;
         if ($urandom_range(0, 59) == 0) s = ~s;
         step($urandom_range(0, 399) != 0, b, s);
      end

      step(1'b1, 1'b0, 1'b0);
      #5;
      drv_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
